// File: rtl/wb_stage_pkg.sv
// Shared encodings and types for the write-back stage.
package wb_stage_pkg;

  localparam logic [2:0] WB_ALU = 3'b000;
  localparam logic [2:0] WB_MEM = 3'b001;
  localparam logic [2:0] WB_PC4 = 3'b010;
  localparam logic [2:0] WB_IMM = 3'b011;
  localparam logic [2:0] WB_PCT = 3'b100;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [0:0] state_t;
  localparam state_t StRun    = 1'b0;
  localparam state_t StWaitLd = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic [2:0]  wb_sel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [31:0] pc_target;
  } memwb_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts and extends the addressed byte/halfword of a loaded word.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    // Halfwords are selected by offset[1] alone; misaligned bit 0 is dropped.
    half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

    case (funct3_i)
      F3_LB:   value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value_o = {24'h0, byte_sel};
      F3_LH:   value_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value_o = {16'h0, half_sel};
      default: value_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load-wait FSM and result selection.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        validM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  WriteBackM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ImmExtM,
  input  logic [31:0] PCTargetM,
  input  logic [31:0] ReadDataM,
  input  logic        mem_rvalid,
  output logic        we3,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW,
  output logic        stallW,
  output logic [7:0]  ld_wait_cnt
);

  memwb_t      memwb_q, memwb_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        load_w;
  logic [31:0] load_value;

  assign load_w = memwb_q.valid && memwb_q.mem_read && (memwb_q.wb_sel == WB_MEM);
  assign stallW = load_w && !mem_rvalid;

  load_align u_load_align (
    .data_i   (ReadDataM),
    .offset_i (memwb_q.alu_result[1:0]),
    .funct3_i (memwb_q.funct3),
    .value_o  (load_value)
  );

  always_comb begin
    memwb_d = memwb_q;
    if (!stallW) begin
      memwb_d = '{valid:      validM,
                  reg_write:  RegWriteM,
                  mem_read:   MemReadM,
                  wb_sel:     WriteBackM,
                  funct3:     funct3M,
                  rd:         RdM,
                  alu_result: ALUResultM,
                  pc_plus4:   PCPlus4M,
                  imm_ext:    ImmExtM,
                  pc_target:  PCTargetM};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:    if (stallW) state_d = StWaitLd;
      default:  if (mem_rvalid) state_d = StRun;
    endcase
  end

  // Counts every stalled cycle of the current load, including the first one
  // spent in RUN, so the value seen alongside rvalid is the full wait length.
  always_comb begin
    cnt_d = '0;
    if (stallW) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memwb_q <= '0;
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      memwb_q <= memwb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    case (memwb_q.wb_sel)
      WB_MEM:  ResultW = load_value;
      WB_PC4:  ResultW = memwb_q.pc_plus4;
      WB_IMM:  ResultW = memwb_q.imm_ext;
      WB_PCT:  ResultW = memwb_q.pc_target;
      default: ResultW = memwb_q.alu_result;
    endcase
  end

  assign we3 = memwb_q.valid && memwb_q.reg_write && (memwb_q.rd != 5'd0)
               && (!load_w || mem_rvalid);
  assign RdW         = memwb_q.rd;
  assign ld_wait_cnt = cnt_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have these ports; clock and reset come first:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- validM  in  1  MEM-stage instruction valid.
- RegWriteM  in  1  instruction writes rd.
- MemReadM  in  1  instruction is a load.
- WriteBackM  in  3  result-select code (REQ-008).
- funct3M  in  3  load width/sign.
- RdM  in  5  destination register.
- ALUResultM  in  32  ALU result / load address.
- PCPlus4M  in  32  PC+4 (JAL/JALR link).
- ImmExtM  in  32  immediate (LUI).
- PCTargetM  in  32  PC+imm (AUIPC).
- ReadDataM  in  32  data-memory read word.
- mem_rvalid  in  1  ReadDataM valid this cycle.
- we3  out  1  register-file write enable.
- RdW  out  5  register-file write address.
- ResultW  out  32  register-file write data / forwarding value.
- stallW  out  1  hold request to all earlier pipeline registers.
- ld_wait_cnt  out  8  saturating count of cycles the current load has waited.

Function
REQ-002 An internal MEM/WB register SHALL capture every M-side input except ReadDataM and mem_rvalid on each rising clk edge when stallW=0.
REQ-003 When stallW=1, the MEM/WB register SHALL hold its contents.
REQ-004 loadW SHALL be defined as validW AND MemReadW AND (WriteBackW=001).
REQ-005 The FSM SHALL have two states, RUN and WAIT_LD.
- RUN->WAIT_LD: loadW=1 and mem_rvalid=0.
- WAIT_LD->RUN: mem_rvalid=1.
- All other cases: the FSM SHALL stay in its current state.
REQ-006 stallW SHALL equal loadW AND NOT mem_rvalid (combinational); stallW is 0 for non-load instructions.
REQ-007 we3 SHALL equal validW AND RegWriteW AND (RdW!=0) AND (NOT loadW OR mem_rvalid); writes to x0 are suppressed.
REQ-008 ResultW SHALL be selected combinationally from WriteBackW:
- 000: ALUResultW.
- 001: aligned load data (REQ-009).
- 010: PCPlus4W.
- 011: ImmExtW.
- 100: PCTargetW.
- 101-111: ALUResultW.
REQ-009 Load alignment SHALL use offset = ALUResultW[1:0] and funct3W:
- 000 LB: byte at the offset, sign-extended.
- 100 LBU: byte at the offset, zero-extended.
- 001 LH: halfword selected by offset[1], sign-extended.
- 101 LHU: halfword selected by offset[1], zero-extended.
- 010 and other codes: full word.
- offset[0] is ignored for halfword loads.
REQ-010 Load data SHALL be taken from ReadDataM in the cycle mem_rvalid=1; the block has no internal data buffer, so total latency is 0 cycles after rvalid.
REQ-011 ld_wait_cnt SHALL clear to 0 in RUN.
REQ-012 ld_wait_cnt SHALL increment once per cycle while the block is in WAIT_LD with mem_rvalid=0, saturating at 255.
REQ-013 ld_wait_cnt SHALL clear on the cycle the block returns to RUN.
REQ-014 Back-to-back loads SHALL each be processed independently; a load whose mem_rvalid arrives in its first W cycle causes no stall.
REQ-015 If validM=0, the MEM/WB register SHALL capture a bubble: validW=0, so we3=0 and stallW=0.
REQ-016 mem_rvalid asserted while loadW=0 SHALL be ignored.

Reset
REQ-017 While reset=1 at a clk edge:
- validW and all MEM/WB fields SHALL clear to 0.
- The FSM SHALL enter RUN.
- ld_wait_cnt SHALL clear to 0.
REQ-018 After reset, outputs SHALL be we3=0, RdW=0, ResultW=0, stallW=0.
REQ-019 Reset asserted during WAIT_LD SHALL abandon the pending load without issuing a write; a late mem_rvalid after reset is ignored per REQ-016.
REQ-020 Reset SHALL take priority over stall hold.

Structure
REQ-021 A shared package SHALL hold:
- the WriteBack encodings (WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PCT);
- the load funct3 constants;
- the FSM state type.
REQ-022 Load alignment SHALL be a purely combinational sub-module named load_align (inputs data, offset, funct3; output 32-bit value).
REQ-023 The FSM and the MEM/WB register SHALL reside in wb_stage.

Verification
REQ-024 ALU write: RegWriteM=1, WB=000, RdM=5, ALUResultM=0x12345678 -> next cycle we3=1, RdW=5, ResultW=0x12345678, stallW=0.
REQ-025 LB, immediate data: funct3=000, address ends 0x3, ReadDataM=0x80FFFFFF with rvalid in the first W cycle -> ResultW=0xFFFFFF80, we3=1, no stall.
REQ-026 LHU, 3-cycle wait: address ends 0x2, rvalid after 3 cycles, data=0xBEEF0000 -> stallW=1 for 3 cycles, ld_wait_cnt reaches 3, then ResultW=0x0000BEEF with we3=1, and the next instruction is not lost.
REQ-027 Write to x0: RdM=0, RegWriteM=1, WB=010 -> we3=0; ResultW still equals PCPlus4.
REQ-028 Reset mid-wait: reset asserted in WAIT_LD, then rvalid=1 -> we3 never 1, stallW=0, FSM in RUN.
REQ-029 Saturation: rvalid withheld for 300 cycles -> ld_wait_cnt holds at 255 and stallW stays 1 throughout.
